// File: rtl/node_in_buf.sv
// node_in_buf: credit-managed flit buffer between the router's local output
// port and a neuromorphic node's flit_in/credit_out pair.
// A 2^B-entry FIFO absorbs router bursts. Flits go to the node only while
// downstream credits remain. One credit returns upstream for each flit popped.
// Optional statistics counters are enabled by defining NODE_IN_BUF_STAT_EN.
module node_in_buf #(
    parameter int FW       = 59,
    parameter int B        = 4,
    parameter int DN_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          up_flit_in_wr,
    input  logic [FW-1:0] up_flit_in,
    output logic          up_credit_out,
    output logic          dn_flit_out_wr,
    output logic [FW-1:0] dn_flit_out,
    input  logic          dn_credit_in,
    output logic [B:0]    occupancy,
    output logic          ovf_err,
    output logic          cred_err,
    output logic [31:0]   stat_flit_cnt,
    output logic [15:0]   stat_drop_cnt
);

    localparam int D = 1 << B;
    localparam logic [7:0] DN_INIT = 8'(DN_DEPTH);
    localparam logic [B:0] ONE     = {{B{1'b0}}, 1'b1};

    logic [FW-1:0] mem [D];
    logic [B:0]    wr_ptr;
    logic [B:0]    rd_ptr;
    logic [7:0]    dn_cred;
    logic [7:0]    dn_cred_next;
    logic          cred_err_set;
    logic [B:0]    occ_next;

    logic empty;
    logic full;
    logic pop;
    logic accept;

    // Full is judged on the pre-pop pointers. A pop in the same cycle still
    // frees a slot, so a write into a full FIFO is accepted when a pop happens.
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[B] != rd_ptr[B]) && (wr_ptr[B-1:0] == rd_ptr[B-1:0]);
    assign pop    = !empty && (dn_cred != 8'd0);
    assign accept = up_flit_in_wr && (!full || pop);

    // Downstream credit bookkeeping. A pop and a returned credit in the same
    // cycle cancel out. A surplus credit with no pop flags cred_err and is dropped.
    always_comb begin
        dn_cred_next = dn_cred;
        cred_err_set = 1'b0;
        case ({pop, dn_credit_in})
            2'b10: dn_cred_next = dn_cred - 8'd1;
            2'b01: begin
                if (dn_cred == DN_INIT) begin
                    cred_err_set = 1'b1;
                end else begin
                    dn_cred_next = dn_cred + 8'd1;
                end
            end
            default: dn_cred_next = dn_cred;
        endcase
    end

    // Entry count after this edge, tracked alongside the pointers.
    always_comb begin
        occ_next = occupancy;
        case ({accept, pop})
            2'b10:   occ_next = occupancy + ONE;
            2'b01:   occ_next = occupancy - ONE;
            default: occ_next = occupancy;
        endcase
    end

    // Storage array. It has no reset because the pointers decide which
    // entries are live.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr[B-1:0]] <= up_flit_in;
        end
    end

    // Pointers, credits, registered outputs and sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            dn_cred        <= DN_INIT;
            occupancy      <= '0;
            dn_flit_out_wr <= 1'b0;
            dn_flit_out    <= '0;
            up_credit_out  <= 1'b0;
            ovf_err        <= 1'b0;
            cred_err       <= 1'b0;
        end else begin
            dn_flit_out_wr <= pop;
            up_credit_out  <= pop;
            if (pop) begin
                dn_flit_out <= mem[rd_ptr[B-1:0]];
                rd_ptr      <= rd_ptr + ONE;
            end
            if (accept) begin
                wr_ptr <= wr_ptr + ONE;
            end
            if (up_flit_in_wr && !accept) begin
                ovf_err <= 1'b1;
            end
            if (cred_err_set) begin
                cred_err <= 1'b1;
            end
            dn_cred   <= dn_cred_next;
            occupancy <= occ_next;
        end
    end

`ifdef NODE_IN_BUF_STAT_EN
    logic [31:0] flit_cnt_q;
    logic [15:0] drop_cnt_q;
    logic        drop;

    assign drop = up_flit_in_wr && !accept;

    // Accepted-flit count wraps. Dropped-flit count saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flit_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (accept) begin
                flit_cnt_q <= flit_cnt_q + 32'd1;
            end
            if (drop && (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
    end

    assign stat_flit_cnt = flit_cnt_q;
    assign stat_drop_cnt = drop_cnt_q;
`else
    assign stat_flit_cnt = '0;
    assign stat_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_node_in_buf.sv
// Testbench for node_in_buf. Stimulus pushes the expected flits into a
// scoreboard queue. A monitor pops the queue and compares each forwarded flit.
module tb_node_in_buf;

    localparam int FW = 59;
    localparam int B  = 4;

`ifdef NODE_IN_BUF_STAT_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          up_flit_in_wr = 1'b0;
    logic [FW-1:0] up_flit_in = '0;
    logic          up_credit_out;
    logic          dn_flit_out_wr;
    logic [FW-1:0] dn_flit_out;
    logic          dn_credit_in = 1'b0;
    logic [B:0]    occupancy;
    logic          ovf_err;
    logic          cred_err;
    logic [31:0]   stat_flit_cnt;
    logic [15:0]   stat_drop_cnt;

    int n_checks  = 0;
    int n_pass    = 0;
    int fwd_cnt   = 0;
    int ucred_cnt = 0;
    int f0        = 0;
    int c0        = 0;

    logic [FW-1:0] sc_q [$];

    node_in_buf #(.FW(FW), .B(B), .DN_DEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .up_flit_in_wr  (up_flit_in_wr),
        .up_flit_in     (up_flit_in),
        .up_credit_out  (up_credit_out),
        .dn_flit_out_wr (dn_flit_out_wr),
        .dn_flit_out    (dn_flit_out),
        .dn_credit_in   (dn_credit_in),
        .occupancy      (occupancy),
        .ovf_err        (ovf_err),
        .cred_err       (cred_err),
        .stat_flit_cnt  (stat_flit_cnt),
        .stat_drop_cnt  (stat_drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // Drive one cycle of inputs. Optionally record the flit as expected output.
    // The task returns 1 time unit after the following falling edge.
    task automatic applyStimulus(input logic wr, input logic [FW-1:0] f, input logic cr, input bit push);
        up_flit_in_wr = wr;
        up_flit_in    = f;
        dn_credit_in  = cr;
        if (push) sc_q.push_back(f);
        @(negedge clk);
        #1;
        up_flit_in_wr = 1'b0;
        dn_credit_in  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0);
    endtask

    // Monitor: compare every forwarded flit against the scoreboard head.
    always @(negedge clk) begin
        if (!rst) begin
            if (dn_flit_out_wr) begin
                fwd_cnt++;
                if (sc_q.size() == 0) begin
                    n_checks++;
                    $display("[TB] FAIL unexpected_flit: got 0x%0h, want no flit", dn_flit_out);
                end else begin
                    checkOutput("flit_data", 64'(dn_flit_out), 64'(sc_q.pop_front()));
                end
            end
            if (up_credit_out) ucred_cnt++;
        end
    end

    // Watchdog so a stuck run still ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #1 rst = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("rst_up_credit", 64'(up_credit_out), 64'd0);
        checkOutput("rst_dn_wr", 64'(dn_flit_out_wr), 64'd0);
        checkOutput("rst_dn_flit", 64'(dn_flit_out), 64'd0);
        checkOutput("rst_occ", 64'(occupancy), 64'd0);
        checkOutput("rst_ovf", 64'(ovf_err), 64'd0);
        checkOutput("rst_cred_err", 64'(cred_err), 64'd0);
        checkOutput("rst_stat_flit", 64'(stat_flit_cnt), 64'd0);
        checkOutput("rst_stat_drop", 64'(stat_drop_cnt), 64'd0);
        rst = 1'b0;
        idle(1);

        // Single flit: present after 1 edge, forwarded on the 2nd edge.
        applyStimulus(1'b1, 59'h1234, 1'b0, 1'b1);
        checkOutput("t1_occ1", 64'(occupancy), 64'd1);
        checkOutput("t1_wr_early", 64'(dn_flit_out_wr), 64'd0);
        idle(1);
        checkOutput("t1_wr", 64'(dn_flit_out_wr), 64'd1);
        checkOutput("t1_flit", 64'(dn_flit_out), 64'h1234);
        checkOutput("t1_upcred", 64'(up_credit_out), 64'd1);
        checkOutput("t1_occ0", 64'(occupancy), 64'd0);
        idle(1);
        checkOutput("t1_wr_low", 64'(dn_flit_out_wr), 64'd0);
        checkOutput("t1_flit_hold", 64'(dn_flit_out), 64'h1234);
        checkOutput("t1_upcred_low", 64'(up_credit_out), 64'd0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);

        // Ten back-to-back flits with four node credits.
        f0 = fwd_cnt;
        c0 = ucred_cnt;
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 59'(64'h100 + 64'(i)), 1'b0, 1'b1);
        idle(3);
        checkOutput("t2_fwd4", 64'(fwd_cnt - f0), 64'd4);
        checkOutput("t2_cred4", 64'(ucred_cnt - c0), 64'd4);
        checkOutput("t2_occ6", 64'(occupancy), 64'd6);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
        idle(3);
        checkOutput("t2_fwd10", 64'(fwd_cnt - f0), 64'd10);
        checkOutput("t2_cred10", 64'(ucred_cnt - c0), 64'd10);
        checkOutput("t2_occ0", 64'(occupancy), 64'd0);

        // Fill all 16 entries while the node holds every credit.
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 59'(64'h200 + 64'(i)), 1'b0, 1'b1);
        checkOutput("fill_occ16", 64'(occupancy), 64'd16);
        checkOutput("fill_ovf0", 64'(ovf_err), 64'd0);
        checkOutput("fill_nofwd", 64'(fwd_cnt - f0), 64'd10);

        // Full FIFO with one credit: a write in the pop cycle is accepted.
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("t4_occ_pre", 64'(occupancy), 64'd16);
        applyStimulus(1'b1, 59'h3AA, 1'b0, 1'b1);
        checkOutput("t4_occ16", 64'(occupancy), 64'd16);
        checkOutput("t4_ovf0", 64'(ovf_err), 64'd0);
        checkOutput("t4_popped", 64'(dn_flit_out_wr), 64'd1);

        // Full FIFO with no credits: the write is dropped.
        applyStimulus(1'b1, 59'h3BB, 1'b0, 1'b0);
        checkOutput("t3_ovf1", 64'(ovf_err), 64'd1);
        checkOutput("t3_occ16", 64'(occupancy), 64'd16);
        checkOutput("t3_stat_drop", 64'(stat_drop_cnt), STAT ? 64'd1 : 64'd0);
        checkOutput("t3_stat_flit", 64'(stat_flit_cnt), STAT ? 64'd28 : 64'd0);

        // Drain the FIFO by returning 16 credits.
        for (int i = 0; i < 16; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
        idle(3);
        checkOutput("drain_occ0", 64'(occupancy), 64'd0);
        checkOutput("drain_fwd", 64'(fwd_cnt - f0), 64'd27);
        checkOutput("drain_cred", 64'(ucred_cnt - c0), 64'd27);

        // Return the four held node slots, then send one surplus credit.
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("t5_cred_err0", 64'(cred_err), 64'd0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("t5_cred_err1", 64'(cred_err), 64'd1);

        // The credit counter stays at 4, so only 4 of 6 flits go out.
        f0 = fwd_cnt;
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 59'(64'h300 + 64'(i)), 1'b0, 1'b1);
        idle(3);
        checkOutput("t5_fwd4", 64'(fwd_cnt - f0), 64'd4);
        checkOutput("t5_occ2", 64'(occupancy), 64'd2);

        // A credit and a pop in the same cycle leave the counter unchanged.
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        idle(2);
        checkOutput("t5_fwd6", 64'(fwd_cnt - f0), 64'd6);
        checkOutput("t5_occ0", 64'(occupancy), 64'd0);
        applyStimulus(1'b1, 59'h4CC, 1'b0, 1'b0);
        idle(3);
        checkOutput("t5_held", 64'(occupancy), 64'd1);
        checkOutput("t5_fwd_same", 64'(fwd_cnt - f0), 64'd6);

        // Queue 5 entries, start a pop, then reset in the middle of the burst.
        sc_q.push_back(59'h4CC);
        applyStimulus(1'b1, 59'h501, 1'b0, 1'b0);
        applyStimulus(1'b1, 59'h502, 1'b0, 1'b0);
        applyStimulus(1'b1, 59'h503, 1'b0, 1'b0);
        applyStimulus(1'b1, 59'h504, 1'b1, 1'b0);
        checkOutput("rm_occ5", 64'(occupancy), 64'd5);
        idle(1);
        checkOutput("rm_inflight", 64'(dn_flit_out_wr), 64'd1);
        checkOutput("rm_ovf_sticky", 64'(ovf_err), 64'd1);
        checkOutput("rm_cred_sticky", 64'(cred_err), 64'd1);
        #1 rst = 1'b1;
        #1;
        checkOutput("rm_dn_wr", 64'(dn_flit_out_wr), 64'd0);
        checkOutput("rm_dn_flit", 64'(dn_flit_out), 64'd0);
        checkOutput("rm_upcred", 64'(up_credit_out), 64'd0);
        checkOutput("rm_occ", 64'(occupancy), 64'd0);
        checkOutput("rm_ovf", 64'(ovf_err), 64'd0);
        checkOutput("rm_cred_err", 64'(cred_err), 64'd0);
        checkOutput("rm_stat_flit", 64'(stat_flit_cnt), 64'd0);
        sc_q.delete();
        @(negedge clk);
        #1 rst = 1'b0;
        f0 = fwd_cnt;
        c0 = ucred_cnt;
        idle(5);
        checkOutput("rm_nostale", 64'(fwd_cnt - f0), 64'd0);
        checkOutput("rm_nocred", 64'(ucred_cnt - c0), 64'd0);

        // After reset the credit counter is back to 4.
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 59'(64'h600 + 64'(i)), 1'b0, 1'b1);
        idle(3);
        checkOutput("pr_fwd4", 64'(fwd_cnt - f0), 64'd4);
        checkOutput("pr_occ2", 64'(occupancy), 64'd2);
        checkOutput("pr_stat_flit", 64'(stat_flit_cnt), STAT ? 64'd6 : 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/node_in_buf.md
# node_in_buf

Credit-managed flit buffer between the mesh router's local output port and a neuromorphic node's `flit_in`/`credit_out` pair. It absorbs bursts from the router in a 2^B-entry FIFO and returns one credit upstream per flit drained. It forwards flits to the node only while it holds downstream credits, mirroring the node's spike-input buffer depth. The block carries spike and config flits alike and never inspects or reorders them.

## Interface
- `FW`, 59, flit width
- `B`, 4, log2 of FIFO depth (depth D = 2^B = 16)
- `DN_DEPTH`, 4, downstream (node) credit count after reset; 1..255
- `clk` input 1 system clock, all state on rising edge
- `rst` input 1 reset, asynchronous, active-high
- `up_flit_in_wr` input 1 router presents a flit this cycle
- `up_flit_in` input FW flit from router
- `up_credit_out` output 1 one-cycle pulse, one buffer slot freed, to router
- `dn_flit_out_wr` output 1 flit valid to node `flit_in_wr`
- `dn_flit_out` output FW flit to node `flit_in`
- `dn_credit_in` input 1 one-cycle pulse from node `credit_out`, one node slot freed
- `occupancy` output B+1 current FIFO entry count, 0..D
- `ovf_err` output 1 sticky: write dropped while full
- `cred_err` output 1 sticky: credit received with counter already at DN_DEPTH
- `stat_flit_cnt` output 32 accepted-flit counter (see Configuration)
- `stat_drop_cnt` output 16 dropped-flit counter, saturating (see Configuration)

## Operation
- FIFO: D entries; read/write pointers are B+1 bits wide and wrap modulo 2D. Empty when the pointers are equal. Full when the MSBs differ and the low B bits are equal.
- Pop condition: `pop = !empty && dn_cred != 0`, evaluated every cycle.
- Write acceptance:
  - A write is accepted when `!full || pop`; full is evaluated before the same-cycle pop.
  - Otherwise the flit is discarded, `ovf_err` is set, and no state other than the stats changes.
- Downstream credit counter `dn_cred` (8 bits):
  - Reset value: DN_DEPTH.
  - Decrements on pop and increments on `dn_credit_in`.
  - Pop and credit in the same cycle: `dn_cred` is unchanged.
  - Increment while at DN_DEPTH with no pop: the counter holds and `cred_err` is set.
- Upstream credits: exactly one `up_credit_out` pulse per popped entry. Dropped flits return no credit.
- Sticky flags clear only on `rst`.
- Reset mid-operation: FIFO is emptied, in-flight output is squashed (`dn_flit_out_wr`=0), and no credit pulse is emitted. The router and node are reset together by system convention.
- Reset values: `up_credit_out`=0, `dn_flit_out_wr`=0, `dn_flit_out`=0, `occupancy`=0, `ovf_err`=0, `cred_err`=0, stats=0.

## Timing
- Write: `up_flit_in` is sampled at edge k and is in the FIFO after edge k.
- Pop:
  - Decision is combinational from post-edge state.
  - `dn_flit_out`/`dn_flit_out_wr` are registered at the next edge.
  - Minimum latency from `up_flit_in_wr` to `dn_flit_out_wr` is 2 edges (empty FIFO, credit available).
- `up_credit_out` is registered on the same edge as the corresponding `dn_flit_out_wr`.
- Throughput: one flit per cycle sustained while `dn_cred` > 0.
- `dn_flit_out` holds its last value when `dn_flit_out_wr`=0.
- `occupancy` is registered and reflects the count after each edge.
- `dn_credit_in` at edge k lets a pop decided in the cycle after edge k proceed.

## Configuration
- Macro: `NODE_IN_BUF_STAT_EN`.
- Defined:
  - `stat_flit_cnt` increments (wrapping) on each accepted write.
  - `stat_drop_cnt` increments on each dropped write and saturates at 16'hFFFF.
- Undefined: the counter logic is not compiled and both ports are tied to 0. `ovf_err`/`cred_err` still function.

## Test plan
- Single flit 59'h1234 with empty FIFO and `dn_cred`=4 -> `dn_flit_out_wr` 2 edges later with 59'h1234. `up_credit_out` pulses the same cycle. `occupancy` goes 1 then 0.
- No `dn_credit_in` and 10 back-to-back flits -> exactly 4 flits forwarded on consecutive cycles and 4 `up_credit_out` pulses. `occupancy` settles at 6. Then 6 `dn_credit_in` pulses -> the remaining 6 flits forwarded in order.
- Fill 16 entries with `dn_cred`=0, then write a 17th flit -> it is dropped, `ovf_err`=1, `occupancy` stays 16. `stat_drop_cnt`=1 with the macro defined, 0 without.
- Full FIFO, `dn_cred`=1, write in the same cycle as the pop -> write accepted, `occupancy` stays 16, `ovf_err` stays 0.
- `dn_credit_in` pulse with `dn_cred`=4 and no pop -> `cred_err`=1, `dn_cred` stays 4. Simultaneous credit and pop -> `dn_cred` unchanged.
- Assert `rst` mid-burst with 5 entries queued -> all outputs 0 immediately. After release, no stale flit is forwarded and `dn_cred`=4.
